vmask_popc_seq: RTL and testbench
=================================

VMASK_POPC_SEQ -- requirements
Module: vmask_popc_seq

Interface
REQ-001 SHALL have parameter VLEN, default 256: mask register width in bits; a multiple of LANE_W.
REQ-002 SHALL have parameter LANE_W, default 32: mask bits consumed per cycle; power of two, 8..VLEN.
REQ-003 SHALL have parameter XLEN, default 32: result width.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_valid  in  1  operation request.
- start_ready  out  1  block can accept a request.
- mode  in  1  0 = CPOP (count set bits), 1 = FIRST (index of lowest set bit).
- mask_in  in  VLEN  source mask vector.
- v0_in  in  VLEN  element-enable mask.
- use_vm  in  1  1 = apply v0_in, 0 = all elements enabled.
- vl  in  $clog2(VLEN+1)  active element count.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  XLEN  result.

Function
REQ-005 SHALL run an FSM with states IDLE, RUN and DONE; start_ready = 1 only in IDLE.
REQ-006 SHALL accept a request on a clk edge where start_valid && start_ready, and SHALL latch mode, mask_in, v0_in, use_vm and vl; later input changes SHALL have no effect until the next accept.
REQ-007 SHALL define effective bit i = mask_in[i] & (use_vm ? v0_in[i] : 1) & (i < vl).
REQ-008 On accept with vl == 0, SHALL go IDLE->DONE with res_data = 0 (CPOP) or all-ones (FIRST).
REQ-009 On accept with vl > 0, SHALL go to RUN with chunk index k = 0 and accumulator = 0.
REQ-010 In RUN, each cycle SHALL process chunk k (bits k*LANE_W .. k*LANE_W+LANE_W-1) and then increment k.
REQ-011 CPOP: each cycle SHALL add popcount(chunk k) to the accumulator; the accumulator is $clog2(VLEN+1) bits wide and cannot overflow.
REQ-012 CPOP SHALL leave RUN after the chunk that contains element vl-1; RUN lasts ceil(vl/LANE_W) cycles.
REQ-013 FIRST SHALL leave RUN after the first chunk with any effective bit set, recording k*LANE_W + (index of the lowest set bit in that chunk).
REQ-014 FIRST with no effective bit set SHALL leave RUN after the chunk containing element vl-1, with result all-ones.
REQ-015 On leaving RUN, SHALL enter DONE on the next edge with res_valid = 1 and res_data = the result zero-extended to XLEN.
REQ-016 In DONE, SHALL hold res_valid and res_data stable while res_ready = 0.
REQ-017 On an edge with res_valid && res_ready, SHALL return to IDLE.
REQ-018 A new request SHALL be accepted no earlier than the cycle after the previous result is consumed; there is no result/request overlap.
REQ-019 SHALL take exactly 1 + RUN-cycles edges from accept to res_valid for vl > 0, and exactly 1 edge for vl == 0.
REQ-020 res_data SHALL be 0 whenever res_valid = 0.

Reset
REQ-021 While rst = 1, SHALL force: state IDLE, start_ready = 1, res_valid = 0, res_data = 0, accumulator = 0, k = 0, and clear all latched operands.
REQ-022 Reset asserted during RUN or DONE SHALL abort the operation; no result SHALL be produced for it.
REQ-023 After rst deasserts, SHALL accept a request on the first clk edge.

Structure
REQ-024 A shared package vmask_pkg SHALL hold the state enum (IDLE/RUN/DONE), the mode enum (CPOP/FIRST) and the default VLEN/LANE_W constants.
REQ-025 The LANE_W-bit population count SHALL be a separate combinational sub-module popcnt_csa #(W):
- structure: a full-adder/half-adder carry-save compressor tree ending in a single adder;
- output width: $clog2(W+1).
REQ-026 The lowest-set-bit search SHALL stay inside vmask_popc_seq.

Verification
All scenarios use the defaults VLEN = 256, LANE_W = 32.
REQ-027 CPOP, mask all-ones, vl = 256, use_vm = 0 -> res_data = 256; res_valid 9 edges after accept.
REQ-028 CPOP, mask all-ones, vl = 37 -> res_data = 37; RUN lasts 2 cycles; res_valid 3 edges after accept.
REQ-029 CPOP, mask all-ones, use_vm = 1, v0 = 0x5555...5, vl = 256 -> res_data = 128.
REQ-030 FIRST, only mask bit 70 set, vl = 256 -> res_data = 70 after 3 RUN cycles; FIRST, only bit 100 set, vl = 100 -> res_data = 0xFFFFFFFF.
REQ-031 FIRST, vl = 0 -> res_valid 1 edge after accept with res_data = 0xFFFFFFFF; hold res_ready = 0 for 5 cycles -> res_data stable and start_ready = 0 throughout.
REQ-032 Assert rst in the 4th RUN cycle of a CPOP -> outputs at reset values immediately, no res_valid afterwards, and the next request gives a correct fresh result.

Source files
------------

// File: rtl/vmask_pkg.sv
// Shared types and default geometry for the vector-mask popcount / find-first sequencer.
package vmask_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        CPOP  = 1'b0,
        FIRST = 1'b1
    } mode_e;

    localparam int VMASK_VLEN   = 256;
    localparam int VMASK_LANE_W = 32;

endpackage

// File: rtl/popcnt_csa.sv
// Combinational population count. Operands start as W one-bit values and are
// reduced three-to-two by rows of full adders until two remain. Those two are
// summed by one final carry-propagate adder.
module popcnt_csa #(
    parameter int W = 32,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [OW-1:0] o_cnt
);

    logic [OW-1:0] w_ops [W];
    logic [OW-1:0] w_nxt [W];
    int            w_n;
    int            w_m;

    // Carry-save reduction. w_n tracks the live operand count, which is an
    // elaboration-time constant at every level.
    always_comb begin
        w_ops = '{default: '0};
        w_nxt = '{default: '0};
        w_n   = W;
        w_m   = 0;
        for (int i = 0; i < W; i++) begin
            w_ops[i] = OW'(i_bits[i]);
        end
        for (int lvl = 0; lvl < W; lvl++) begin
            if (w_n > 2) begin
                w_nxt = '{default: '0};
                w_m   = 0;
                for (int j = 0; j < W / 3; j++) begin
                    if (3 * j + 2 < w_n) begin
                        w_nxt[w_m]     = w_ops[3*j] ^ w_ops[3*j+1] ^ w_ops[3*j+2];
                        w_nxt[w_m + 1] = ((w_ops[3*j] & w_ops[3*j+1]) |
                                          (w_ops[3*j] & w_ops[3*j+2]) |
                                          (w_ops[3*j+1] & w_ops[3*j+2])) << 1;
                        w_m = w_m + 2;
                    end
                end
                for (int j = 0; j < 2; j++) begin
                    if ((w_n / 3) * 3 + j < w_n) begin
                        w_nxt[w_m] = w_ops[(w_n / 3) * 3 + j];
                        w_m = w_m + 1;
                    end
                end
                w_ops = w_nxt;
                w_n   = w_m;
            end
        end
        o_cnt = w_ops[0] + w_ops[1];
    end

endmodule

// File: rtl/vmask_popc_seq.sv
// Sequential mask popcount (CPOP) / find-first-set (FIRST), one LANE_W chunk per cycle.
//
// state | meaning
// IDLE  | waiting for a request, start_ready high
// RUN   | walking chunks k = 0,1,.. of the latched mask
// DONE  | result presented until res_ready
module vmask_popc_seq
    import vmask_pkg::*;
#(
    parameter int VLEN   = VMASK_VLEN,
    parameter int LANE_W = VMASK_LANE_W,
    parameter int XLEN   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic                       mode,
    input  logic [VLEN-1:0]            mask_in,
    input  logic [VLEN-1:0]            v0_in,
    input  logic                       use_vm,
    input  logic [$clog2(VLEN+1)-1:0]  vl,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [XLEN-1:0]            res_data
);

    localparam int VLW = $clog2(VLEN + 1);
    localparam int NCH = VLEN / LANE_W;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = $clog2(LANE_W);
    localparam int CW  = $clog2(LANE_W + 1);

    state_e          r_state;
    state_e          w_state_nxt;
    mode_e           r_mode;
    logic [VLEN-1:0] r_mask;
    logic [VLEN-1:0] r_v0;
    logic            r_use_vm;
    logic [VLW-1:0]  r_vl;
    logic [KW-1:0]   r_k;
    logic [VLW-1:0]  r_acc;
    logic [XLEN-1:0] r_res;

    logic [LANE_W-1:0] w_chunk;
    logic [CW-1:0]     w_cnt;
    logic [LW-1:0]     w_lsb;
    logic              w_any;
    logic              w_last;
    logic              w_run_done;
    logic [XLEN-1:0]   w_run_res;

    // Effective bits of the current chunk: mask, optional v0 enable, and tail beyond vl.
    always_comb begin
        w_chunk = '0;
        for (int b = 0; b < LANE_W; b++) begin
            w_chunk[b] = r_mask[int'(r_k) * LANE_W + b]
                       & (r_use_vm ? r_v0[int'(r_k) * LANE_W + b] : 1'b1)
                       & (VLW'({r_k, LW'(b)}) < r_vl);
        end
    end

    popcnt_csa #(.W(LANE_W)) u_popcnt (
        .i_bits (w_chunk),
        .o_cnt  (w_cnt)
    );

    // Lowest set bit of the chunk; scanning downward lets the lowest index win.
    always_comb begin
        w_lsb = '0;
        for (int i = LANE_W - 1; i >= 0; i--) begin
            if (w_chunk[i]) w_lsb = LW'(i);
        end
    end

    // Chunk holding element vl-1 ends the walk; FIRST may end earlier on a hit.
    always_comb begin
        w_any      = |w_chunk;
        w_last     = ((r_vl - VLW'(1)) >> LW) == VLW'(r_k);
        w_run_done = ((r_mode == FIRST) && w_any) || w_last;
        if (r_mode == CPOP)  w_run_res = XLEN'(r_acc + VLW'(w_cnt));
        else if (w_any)      w_run_res = XLEN'({r_k, w_lsb});
        else                 w_run_res = '1;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        start_ready = (r_state == IDLE);
        res_valid   = (r_state == DONE);
        res_data    = r_res;
        case (r_state)
            IDLE: if (start_valid) w_state_nxt = (vl == '0) ? DONE : RUN;
            RUN:  if (w_run_done)  w_state_nxt = DONE;
            DONE: if (res_ready)   w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand latch, chunk walk and result register; r_res is zero outside DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= CPOP;
            r_mask   <= '0;
            r_v0     <= '0;
            r_use_vm <= 1'b0;
            r_vl     <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_valid) begin
                    r_mode   <= mode_e'(mode);
                    r_mask   <= mask_in;
                    r_v0     <= v0_in;
                    r_use_vm <= use_vm;
                    r_vl     <= vl;
                    r_k      <= '0;
                    r_acc    <= '0;
                    r_res    <= ((vl == '0) && mode) ? '1 : '0;
                end
                RUN: begin
                    r_k   <= r_k + KW'(1);
                    r_acc <= r_acc + VLW'(w_cnt);
                    if (w_run_done) r_res <= w_run_res;
                end
                DONE: if (res_ready) r_res <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vmask_popc_seq.sv
// Directed bench for vmask_popc_seq at VLEN=256, LANE_W=32.
module tb_vmask_popc_seq;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic         mode;
    logic [255:0] mask_in;
    logic [255:0] v0_in;
    logic         use_vm;
    logic [8:0]   vl;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_data;

    int n_vec = 0;
    int n_err = 0;

    vmask_popc_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mode        (mode),
        .mask_in     (mask_in),
        .v0_in       (v0_in),
        .use_vm      (use_vm),
        .vl          (vl),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble inputs after accept, count edges to res_valid,
    // optionally stall the consumer, then consume and confirm return to IDLE.
    task automatic run_op(input string tag, input logic m, input logic [255:0] mk,
                          input logic [255:0] v0, input logic uvm, input logic [8:0] l,
                          input int hold, input logic [31:0] exp_data, input int exp_edges);
        int edges;
        mode = m; mask_in = mk; v0_in = v0; use_vm = uvm; vl = l; start_valid = 1'b1;
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        mask_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        v0_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        use_vm  = 1'($urandom);
        vl      = 9'($urandom);
        mode    = 1'($urandom);
        edges = 1;
        while (!res_valid && edges < 40) begin
            check({tag, "_data_zero"}, res_data, 32'd0);
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        check({tag, "_data"}, res_data, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_hold_data"}, res_data, exp_data);
            check({tag, "_hold_ready"}, 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(start_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_idle_data"}, res_data, 32'd0);
    endtask

    logic [255:0] ones;
    logic [255:0] pat;
    logic [255:0] v0p;
    logic         saw_valid;

    initial begin
        ones = '1;
        rst = 1'b1; start_valid = 1'b0; mode = 1'b0; mask_in = '0; v0_in = '0;
        use_vm = 1'b0; vl = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        rst = 1'b0;

        run_op("cpop_full",    1'b0, ones, '0, 1'b0, 9'd256, 0, 32'd256, 9);
        run_op("cpop_vl37",    1'b0, ones, '0, 1'b0, 9'd37,  0, 32'd37,  3);
        v0p = {64{4'h5}};
        run_op("cpop_vm",      1'b0, ones, v0p, 1'b1, 9'd256, 0, 32'd128, 9);
        pat = 256'hFF_0000_00FF;
        run_op("cpop_tail",    1'b0, pat, '0, 1'b0, 9'd36, 0, 32'd12, 3);
        run_op("cpop_vl0",     1'b0, ones, '0, 1'b0, 9'd0, 0, 32'd0, 1);

        pat = '0; pat[70] = 1'b1;
        run_op("first_70",     1'b1, pat, '0, 1'b0, 9'd256, 0, 32'd70, 4);
        pat = '0; pat[100] = 1'b1;
        run_op("first_vl100",  1'b1, pat, '0, 1'b0, 9'd100, 0, 32'hFFFF_FFFF, 5);
        pat = '0; pat[0] = 1'b1;
        run_op("first_0",      1'b1, pat, '0, 1'b0, 9'd256, 0, 32'd0, 2);
        pat = '0; pat[3] = 1'b1; pat[200] = 1'b1;
        v0p = ones; v0p[3] = 1'b0;
        run_op("first_vm",     1'b1, pat, v0p, 1'b1, 9'd256, 0, 32'd200, 8);
        run_op("first_vl0",    1'b1, ones, '0, 1'b0, 9'd0, 5, 32'hFFFF_FFFF, 1);

        // Abort a CPOP in its 4th RUN cycle.
        mode = 1'b0; mask_in = ones; use_vm = 1'b0; vl = 9'd256; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_data", res_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (res_valid) saw_valid = 1'b1;
        end
        check("abort_no_result", 32'(saw_valid), 32'd0);
        run_op("after_abort",  1'b0, ones, '0, 1'b0, 9'd37, 0, 32'd37, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
